// File: rtl/ssd_pkg.sv
// Shared types, constants and hex-to-segment decode for the seven-segment scanner.
package ssd_pkg;

    localparam int unsigned SEG_W = 7;

    // Active-high "all segments off"; the top flips polarity when needed
    localparam logic [SEG_W-1:0] SSD_OFF = 7'h00;

    typedef enum logic {ST_BLANK, ST_DRIVE} t_scan_state;

    // Segment order {g,f,e,d,c,b,a}, active-high
    function automatic logic [SEG_W-1:0] hex_to_ssd(input logic [3:0] i_nib);
        logic [SEG_W-1:0] r_seg;
        case (i_nib)
            4'h0: r_seg = 7'h3F;
            4'h1: r_seg = 7'h06;
            4'h2: r_seg = 7'h5B;
            4'h3: r_seg = 7'h4F;
            4'h4: r_seg = 7'h66;
            4'h5: r_seg = 7'h6D;
            4'h6: r_seg = 7'h7D;
            4'h7: r_seg = 7'h07;
            4'h8: r_seg = 7'h7F;
            4'h9: r_seg = 7'h67;
            4'hA: r_seg = 7'h77;
            4'hB: r_seg = 7'h7C;
            4'hC: r_seg = 7'h39;
            4'hD: r_seg = 7'h5E;
            4'hE: r_seg = 7'h79;
            4'hF: r_seg = 7'h71;
        endcase
        return r_seg;
    endfunction

endpackage

// File: rtl/ssd_slot_timer.sv
// Free-running slot counter; strobes the last blank cycle and the last slot cycle.
module ssd_slot_timer #(
    parameter int unsigned PAR_SLOT_CYCLES  = 100000,
    parameter int unsigned PAR_BLANK_CYCLES = 400
) (
    input  logic i_clk_20mhz,
    input  logic i_rst_20mhz,
    output logic o_blank_end_c,
    output logic o_slot_end_c
);

    localparam int unsigned CNT_W = (PAR_SLOT_CYCLES > 1) ? $clog2(PAR_SLOT_CYCLES) : 1;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            r_cnt <= '0;
        end else if (o_slot_end_c) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_slot_end_c  = (r_cnt == CNT_W'(PAR_SLOT_CYCLES - 1));
    assign o_blank_end_c = (r_cnt == CNT_W'(PAR_BLANK_CYCLES - 1));

endmodule

// File: rtl/multi_digit_ssd_scanner.sv
// N-digit hex seven-segment scanner with dead-time blanking, double-buffered
// input word, per-digit enables, decimal points and leading-zero suppression.
module multi_digit_ssd_scanner
    import ssd_pkg::*;
#(
    parameter int unsigned PAR_DIGITS       = 4,
    parameter int unsigned PAR_SLOT_CYCLES  = 100000,
    parameter int unsigned PAR_BLANK_CYCLES = 400,
    parameter bit          PAR_SEG_ACT_LOW  = 1'b0
) (
    input  logic                    i_clk_20mhz,
    input  logic                    i_rst_20mhz,
    input  logic [4*PAR_DIGITS-1:0] i_value,
    input  logic [PAR_DIGITS-1:0]   i_dp,
    input  logic [PAR_DIGITS-1:0]   i_digit_en,
    input  logic                    i_lz_suppress,
    input  logic                    i_load,
    output logic [SEG_W-1:0]        o_seg,
    output logic                    o_dp,
    output logic [PAR_DIGITS-1:0]   o_sel,
    output logic                    o_frame_done
);

    localparam int unsigned VAL_W = 4 * PAR_DIGITS;
    localparam int unsigned IDX_W = (PAR_DIGITS > 1) ? $clog2(PAR_DIGITS) : 1;
    localparam logic [SEG_W-1:0] SEG_POL = {SEG_W{PAR_SEG_ACT_LOW}};

    if (PAR_BLANK_CYCLES == 0 || PAR_BLANK_CYCLES >= PAR_SLOT_CYCLES ||
        PAR_DIGITS < 2 || PAR_DIGITS > 8) begin : g_bad_param
        $error("multi_digit_ssd_scanner: illegal PAR_DIGITS/PAR_BLANK_CYCLES/PAR_SLOT_CYCLES");
    end

    logic                 w_blank_end;
    logic                 w_slot_end;
    t_scan_state          r_state;
    t_scan_state          w_state_nxt;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic                 w_frame_c;

    // Enables are held as a disable mask so the all-zero reset shows every digit
    logic [VAL_W-1:0]      r_sh_val;
    logic [PAR_DIGITS-1:0] r_sh_dp;
    logic [PAR_DIGITS-1:0] r_sh_dis;
    logic                  r_sh_lz;
    logic [VAL_W-1:0]      r_ac_val;
    logic [PAR_DIGITS-1:0] r_ac_dp;
    logic [PAR_DIGITS-1:0] r_ac_dis;
    logic                  r_ac_lz;

    logic [PAR_DIGITS-1:0] w_lz_dark;
    logic                  w_zero_run;
    logic [3:0]            w_nib;
    logic                  w_dark;
    logic [PAR_DIGITS-1:0] w_sel_nxt;
    logic [SEG_W-1:0]      w_seg_nxt;
    logic                  w_dp_nxt;

    logic [SEG_W-1:0]      r_seg;
    logic                  r_dp;
    logic [PAR_DIGITS-1:0] r_sel;
    logic                  r_frame_done;

    ssd_slot_timer #(
        .PAR_SLOT_CYCLES  (PAR_SLOT_CYCLES),
        .PAR_BLANK_CYCLES (PAR_BLANK_CYCLES)
    ) u_timer (
        .i_clk_20mhz   (i_clk_20mhz),
        .i_rst_20mhz   (i_rst_20mhz),
        .o_blank_end_c (w_blank_end),
        .o_slot_end_c  (w_slot_end)
    );

    // A digit is a leading zero when it and every digit above it are zero
    always_comb begin
        w_lz_dark  = '0;
        w_zero_run = 1'b1;
        for (int k = PAR_DIGITS - 1; k >= 0; k--) begin
            w_zero_run   = w_zero_run && (r_ac_val[4*k +: 4] == 4'h0);
            w_lz_dark[k] = r_ac_lz && w_zero_run && (k != 0);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_frame_c   = 1'b0;
        w_sel_nxt   = '0;
        w_seg_nxt   = SSD_OFF;
        w_dp_nxt    = 1'b0;
        w_nib       = 4'(r_ac_val >> {r_idx, 2'b00});
        w_dark      = r_ac_dis[r_idx] || w_lz_dark[r_idx];

        case (r_state)
            ST_BLANK: begin
                if (w_blank_end) begin
                    w_state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (w_slot_end) begin
                    w_state_nxt = ST_BLANK;
                    if (r_idx == IDX_W'(PAR_DIGITS - 1)) begin
                        w_idx_nxt = '0;
                        w_frame_c = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            default: w_state_nxt = ST_BLANK;
        endcase

        // Outputs follow the next state so select and segments switch together
        if (w_state_nxt == ST_DRIVE) begin
            w_sel_nxt = PAR_DIGITS'(1) << r_idx;
            if (!w_dark) begin
                w_seg_nxt = hex_to_ssd(w_nib);
                w_dp_nxt  = r_ac_dp[r_idx];
            end
        end
    end

    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            r_state <= ST_BLANK;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            r_sh_val     <= '0;
            r_sh_dp      <= '0;
            r_sh_dis     <= '0;
            r_sh_lz      <= 1'b0;
            r_ac_val     <= '0;
            r_ac_dp      <= '0;
            r_ac_dis     <= '0;
            r_ac_lz      <= 1'b0;
            r_sel        <= '0;
            r_seg        <= SEG_POL;
            r_dp         <= PAR_SEG_ACT_LOW;
            r_frame_done <= 1'b0;
        end else begin
            if (i_load) begin
                r_sh_val <= i_value;
                r_sh_dp  <= i_dp;
                r_sh_dis <= ~i_digit_en;
                r_sh_lz  <= i_lz_suppress;
            end
            // A load on the boundary edge bypasses shadow into the new frame
            if (w_frame_c) begin
                if (i_load) begin
                    r_ac_val <= i_value;
                    r_ac_dp  <= i_dp;
                    r_ac_dis <= ~i_digit_en;
                    r_ac_lz  <= i_lz_suppress;
                end else begin
                    r_ac_val <= r_sh_val;
                    r_ac_dp  <= r_sh_dp;
                    r_ac_dis <= r_sh_dis;
                    r_ac_lz  <= r_sh_lz;
                end
            end
            r_sel        <= w_sel_nxt;
            r_seg        <= w_seg_nxt ^ SEG_POL;
            r_dp         <= w_dp_nxt ^ PAR_SEG_ACT_LOW;
            r_frame_done <= w_frame_c;
        end
    end

    assign o_seg        = r_seg;
    assign o_dp         = r_dp;
    assign o_sel        = r_sel;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_multi_digit_ssd_scanner.sv
// Randomised self-checking bench for multi_digit_ssd_scanner against a cycle-position model.
module tb_multi_digit_ssd_scanner;

    localparam int D     = 4;
    localparam int SLOT  = 10;
    localparam int BLANK = 2;
    localparam int FRAME = D * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        lz = 1'b0;
    logic [15:0] val = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  en = 4'hF;

    logic [6:0]  seg;
    logic        odp;
    logic [3:0]  sel;
    logic        fd;
    logic [6:0]  seg2;
    logic        odp2;
    logic [1:0]  sel2;
    logic        fd2;

    int total = 0;
    int bad   = 0;

    // Model: edges since reset plus shadow/active copies of the display data
    int          t = 0;
    logic [15:0] sh_val, ac_val;
    logic [3:0]  sh_dp, ac_dp, sh_en, ac_en;
    logic        sh_lz, ac_lz;

    always #25 clk = ~clk;

    multi_digit_ssd_scanner #(
        .PAR_DIGITS(D), .PAR_SLOT_CYCLES(SLOT), .PAR_BLANK_CYCLES(BLANK), .PAR_SEG_ACT_LOW(1'b0)
    ) dut (
        .i_clk_20mhz(clk), .i_rst_20mhz(rst), .i_value(val), .i_dp(dp), .i_digit_en(en),
        .i_lz_suppress(lz), .i_load(load), .o_seg(seg), .o_dp(odp), .o_sel(sel), .o_frame_done(fd)
    );

    multi_digit_ssd_scanner #(
        .PAR_DIGITS(2), .PAR_SLOT_CYCLES(SLOT), .PAR_BLANK_CYCLES(BLANK), .PAR_SEG_ACT_LOW(1'b1)
    ) dut2 (
        .i_clk_20mhz(clk), .i_rst_20mhz(rst), .i_value(8'h88), .i_dp(2'b00), .i_digit_en(2'b11),
        .i_lz_suppress(1'b0), .i_load(load), .o_seg(seg2), .o_dp(odp2), .o_sel(sel2), .o_frame_done(fd2)
    );

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] tbl [16];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return tbl[n];
    endfunction

    // Expected {sel, seg, dp, frame_done} of the 4-digit instance at edge t
    function automatic logic [12:0] exp_vec();
        int         cnt, dig;
        logic [3:0] q, nib;
        logic [6:0] s;
        logic       p, dark;
        cnt = t % SLOT;
        dig = (t / SLOT) % D;
        q = '0; s = '0; p = 1'b0;
        if (cnt >= BLANK) begin
            q    = 4'(1 << dig);
            nib  = 4'(ac_val >> (4 * dig));
            dark = !ac_en[dig] || (ac_lz && dig != 0 && (ac_val >> (4 * dig)) == 16'h0);
            if (!dark) begin
                s = hex7(nib);
                p = ac_dp[dig];
            end
        end
        return {q, s, p, (t > 0 && t % FRAME == 0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            t = 0;
            sh_val = '0; sh_dp = '0; sh_en = 4'hF; sh_lz = 1'b0;
            ac_val = '0; ac_dp = '0; ac_en = 4'hF; ac_lz = 1'b0;
        end else begin
            t++;
            if (load) begin
                sh_val = val; sh_dp = dp; sh_en = en; sh_lz = lz;
            end
            if (t % FRAME == 0) begin
                ac_val = sh_val; ac_dp = sh_dp; ac_en = sh_en; ac_lz = sh_lz;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({sel, seg, odp, fd} !== 13'h0) begin
                bad++;
                $display("FAIL reset got=%h exp=%h", {sel, seg, odp, fd}, 13'h0);
            end
            total++;
            if ({sel2, seg2, odp2} !== {2'b00, 7'h7F, 1'b1}) begin
                bad++;
                $display("FAIL reset_act_low got=%h exp=%h", {sel2, seg2, odp2}, {2'b00, 7'h7F, 1'b1});
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_idle_scan();
        for (int i = 0; i < 100; i++) begin
            tick();
            total++;
            if ({sel, seg, odp, fd} !== exp_vec()) begin
                bad++;
                $display("FAIL idle t=%0d got=%h exp=%h", t, {sel, seg, odp, fd}, exp_vec());
            end
        end
    endtask

    task automatic test_hex_pattern();
        val = 16'h12AF; en = 4'hF; dp = 4'b0100; lz = 1'b0; load = 1'b1;
        for (int i = 0; i < 90; i++) begin
            tick();
            load = 1'b0;
            total++;
            if ({sel, seg, odp, fd} !== exp_vec()) begin
                bad++;
                $display("FAIL hex_pattern t=%0d got=%h exp=%h", t, {sel, seg, odp, fd}, exp_vec());
            end
        end
    endtask

    task automatic test_lz_suppress();
        for (int pass = 0; pass < 2; pass++) begin
            val = (pass == 0) ? 16'h0005 : 16'h0000;
            en = 4'hF; dp = 4'h0; lz = 1'b1; load = 1'b1;
            for (int i = 0; i < 90; i++) begin
                tick();
                load = 1'b0;
                total++;
                if ({sel, seg, odp, fd} !== exp_vec()) begin
                    bad++;
                    $display("FAIL lz_suppress t=%0d got=%h exp=%h", t, {sel, seg, odp, fd}, exp_vec());
                end
            end
        end
    endtask

    task automatic test_load_timing();
        // Mid-frame load, then a load landing exactly on the frame boundary
        for (int i = 0; i < FRAME && (t % FRAME) != 15; i++) tick();
        val = 16'hFFFF; en = 4'hF; dp = 4'h0; lz = 1'b0; load = 1'b1;
        for (int i = 0; i < 70; i++) begin
            tick();
            load = 1'b0;
            total++;
            if ({sel, seg, odp, fd} !== exp_vec()) begin
                bad++;
                $display("FAIL mid_frame_load t=%0d got=%h exp=%h", t, {sel, seg, odp, fd}, exp_vec());
            end
        end
        for (int i = 0; i < FRAME && ((t + 1) % FRAME) != 0; i++) tick();
        val = 16'hA5C3; dp = 4'b1001; load = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            load = 1'b0;
            total++;
            if ({sel, seg, odp, fd} !== exp_vec()) begin
                bad++;
                $display("FAIL boundary_load t=%0d got=%h exp=%h", t, {sel, seg, odp, fd}, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < FRAME && !((t / SLOT) % D == 2 && t % SLOT == 5); i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({sel, seg, odp, fd} !== 13'h0) begin
            bad++;
            $display("FAIL reset_mid got=%h exp=%h", {sel, seg, odp, fd}, 13'h0);
        end
        for (int i = 0; i < 50; i++) begin
            tick();
            total++;
            if ({sel, seg, odp, fd} !== exp_vec()) begin
                bad++;
                $display("FAIL after_reset t=%0d got=%h exp=%h", t, {sel, seg, odp, fd}, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 11) == 0 || ((t + 1) % FRAME == 0 && $urandom_range(0, 2) == 0)) begin
                val  = 16'($urandom) >> (4 * $urandom_range(0, 3));
                dp   = 4'($urandom);
                en   = 4'($urandom);
                lz   = 1'($urandom);
                load = 1'b1;
            end
            tick();
            load = 1'b0;
            total++;
            if ({sel, seg, odp, fd} !== exp_vec()) begin
                bad++;
                $display("FAIL random t=%0d got=%h exp=%h", t, {sel, seg, odp, fd}, exp_vec());
            end
        end
    endtask

    task automatic test_act_low();
        logic [10:0] e2;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        val = 16'h0000; en = 4'hF; dp = 4'h0; lz = 1'b0; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (t % SLOT < BLANK) e2 = {2'b00, 7'h7F, 1'b1, (t % 20 == 0)};
            else e2 = {2'(1 << ((t / SLOT) % 2)), (t >= 20) ? 7'h00 : 7'h40, 1'b1, 1'b0};
            total++;
            if ({sel2, seg2, odp2, fd2} !== e2) begin
                bad++;
                $display("FAIL act_low t=%0d got=%h exp=%h", t, {sel2, seg2, odp2, fd2}, e2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_hex_pattern();
        test_lz_suppress();
        test_load_timing();
        test_reset_mid();
        test_random();
        test_act_low();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
